// File: rtl/oram_access_ctrl.sv
// One ORAM access: position-map remap, root-to-leaf path scrub, root re-insert; 2D+5-cycle fixed latency.
// No response backpressure, one access in flight; ORAM_STATS_EN adds saturating access/hit/overflow counters.
module oram_access_ctrl #(
  parameter int D     = 6,
  parameter int K     = 3,
  parameter int A     = 8,
  parameter int VW    = 8 * A,
  parameter int TUP_W = 1 + (D - 1) + D + VW
`ifdef ORAM_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [D-1:0]       req_bnum,
  input  logic [VW-1:0]      req_wdata,
  output logic               rsp_valid,
  output logic [VW-1:0]      rsp_rdata,
  output logic               rsp_hit,
  output logic               overflow,
`ifdef ORAM_STATS_EN
  output logic [CNT_W-1:0]   stat_acc,
  output logic [CNT_W-1:0]   stat_hit,
  output logic [CNT_W-1:0]   stat_ovf,
`endif
  input  logic [D-2:0]       rnd_leaf,
  output logic               pm_re,
  output logic               pm_we,
  output logic [D-1:0]       pm_addr,
  output logic [D-1:0]       pm_wdata,
  input  logic [D-1:0]       pm_rdata,
  output logic               bk_re,
  output logic               bk_we,
  output logic [D-1:0]       bk_addr,
  output logic [K*TUP_W-1:0] bk_wdata,
  input  logic [K*TUP_W-1:0] bk_rdata
);
  localparam int LVL_W = $clog2(D);

  typedef enum logic [2:0] {IDLE, PM_RD, PM_WR, PATH_RD, PATH_WB, ROOT_RD, ROOT_WB, DONE} state_t;

  state_t            state_q, state_d;
  logic [D-1:0]      bnum_q, bnum_d;
  logic              we_q, we_d;
  logic [VW-1:0]     wdata_q, wdata_d;
  logic [D-2:0]      new_leaf_q, new_leaf_d;
  logic [D-2:0]      old_leaf_q, old_leaf_d;
  logic [VW-1:0]     val_q, val_d;
  logic              hit_q, hit_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [D-1:0]      node_q, node_d;
  logic              ovf_q, ovf_d;
  logic [VW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              root_full;
  logic              found;
  logic              placed;
  logic [TUP_W-1:0]  tup;
  logic [TUP_W-1:0]  new_tup;

  assign pm_addr   = bnum_q;
  assign pm_wdata  = {1'b1, new_leaf_q};
  assign overflow  = ovf_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_hit   = rsp_hit_q;

  always_comb begin
    root_full = 1'b1;
    for (int j = 0; j < K; j++) begin
      root_full = root_full & bk_rdata[j*TUP_W + TUP_W - 1];
    end
  end

  always_comb begin
    state_d     = state_q;
    bnum_d      = bnum_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    new_leaf_d  = new_leaf_q;
    old_leaf_d  = old_leaf_q;
    val_d       = val_q;
    hit_d       = hit_q;
    level_d     = level_q;
    node_d      = node_q;
    ovf_d       = ovf_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_hit_d   = rsp_hit_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    pm_re       = 1'b0;
    pm_we       = 1'b0;
    bk_re       = 1'b0;
    bk_we       = 1'b0;
    bk_addr     = '0;
    bk_wdata    = bk_rdata;
    found       = hit_q;
    placed      = 1'b0;
    tup         = '0;
    new_tup     = {1'b1, new_leaf_q, bnum_q, (we_q ? wdata_q : val_q)};
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          bnum_d     = req_bnum;
          we_d       = req_we;
          wdata_d    = req_wdata;
          new_leaf_d = rnd_leaf;
          val_d      = '0;
          hit_d      = 1'b0;
          state_d    = PM_RD;
        end
      end
      PM_RD: begin
        pm_re   = 1'b1;
        state_d = PM_WR;
      end
      PM_WR: begin
        // An unmapped block still walks a random path so the access looks the same.
        pm_we      = 1'b1;
        old_leaf_d = pm_rdata[D-1] ? pm_rdata[D-2:0] : rnd_leaf;
        level_d    = '0;
        node_d     = D'(1);
        state_d    = PATH_RD;
      end
      PATH_RD: begin
        bk_re   = 1'b1;
        bk_addr = node_q - D'(1);
        state_d = PATH_WB;
      end
      PATH_WB: begin
        bk_we   = 1'b1;
        bk_addr = node_q - D'(1);
        for (int j = 0; j < K; j++) begin
          tup = bk_rdata[j*TUP_W +: TUP_W];
          if (tup[TUP_W-1] && (tup[VW +: D] == bnum_q)) begin
            bk_wdata[j*TUP_W + TUP_W - 1] = 1'b0;
            if (!found) begin
              val_d = tup[VW-1:0];
              found = 1'b1;
            end
          end
        end
        hit_d = found;
        if (level_q == LVL_W'(D - 1)) begin
          state_d = ROOT_RD;
        end else begin
          node_d  = {node_q[D-2:0], old_leaf_q[level_q]};
          level_d = level_q + LVL_W'(1);
          state_d = PATH_RD;
        end
      end
      ROOT_RD: begin
        bk_re   = 1'b1;
        state_d = ROOT_WB;
      end
      ROOT_WB: begin
        bk_we = 1'b1;
        for (int j = 0; j < K; j++) begin
          if (!placed && !bk_rdata[j*TUP_W + TUP_W - 1]) begin
            bk_wdata[j*TUP_W +: TUP_W] = new_tup;
            placed = 1'b1;
          end
        end
        if (root_full) ovf_d = 1'b1;
        rsp_rdata_d = val_q;
        rsp_hit_d   = hit_q;
        state_d     = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bnum_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      new_leaf_q  <= '0;
      old_leaf_q  <= '0;
      val_q       <= '0;
      hit_q       <= 1'b0;
      level_q     <= '0;
      node_q      <= '0;
      ovf_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bnum_q      <= bnum_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      new_leaf_q  <= new_leaf_d;
      old_leaf_q  <= old_leaf_d;
      val_q       <= val_d;
      hit_q       <= hit_d;
      level_q     <= level_d;
      node_q      <= node_d;
      ovf_q       <= ovf_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

`ifdef ORAM_STATS_EN
  logic [CNT_W-1:0] stat_acc_q, stat_acc_d;
  logic [CNT_W-1:0] stat_hit_q, stat_hit_d;
  logic [CNT_W-1:0] stat_ovf_q, stat_ovf_d;

  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_hit_d = stat_hit_q;
    stat_ovf_d = stat_ovf_q;
    if ((state_q == IDLE) && req_valid && (stat_acc_q != '1)) stat_acc_d = stat_acc_q + CNT_W'(1);
    if ((state_q == DONE) && rsp_hit_q && (stat_hit_q != '1)) stat_hit_d = stat_hit_q + CNT_W'(1);
    if ((state_q == ROOT_WB) && root_full && (stat_ovf_q != '1)) stat_ovf_d = stat_ovf_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc_q <= '0;
      stat_hit_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_hit_q <= stat_hit_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign stat_acc = stat_acc_q;
  assign stat_hit = stat_hit_q;
  assign stat_ovf = stat_ovf_q;
`endif
endmodule
